regfile_wb_queue: RTL

//  Write-back buffer on the regfile's single write port (rd_addr/rd_data/rd_wren).

---
 rtl/regfile_wb_queue.sv | 108 ++++++++++
 1 files changed

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the regfile's single write port.
// Drains in push order and offers a newest-entry bypass to the decode read ports.
module regfile_wb_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_wb_valid,
  output logic                             o_wb_ready,
  input  logic [ADDR_W-1:0]                i_wb_addr,
  input  logic [DATA_W-1:0]                i_wb_data,
  input  logic                             i_drain_en,
  output logic                             o_rd_wren,
  output logic [ADDR_W-1:0]                o_rd_addr,
  output logic [DATA_W-1:0]                o_rd_data,
  input  logic [ADDR_W-1:0]                i_rs1_addr,
  input  logic [ADDR_W-1:0]                i_rs2_addr,
  output logic                             o_rs1_hit,
  output logic [DATA_W-1:0]                o_rs1_data,
  output logic                             o_rs2_hit,
  output logic [DATA_W-1:0]                o_rs2_data,
  output logic [$clog2(DEPTH+1)-1:0]       o_count,
  output logic                             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic [PTR_W-1:0]  w_idx;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign o_wb_ready = !w_full;
  assign o_count    = r_count;
  assign o_empty    = (r_count == '0);

  // x0 writes complete the handshake but are never stored
  assign w_push    = i_wb_valid && !w_full && (i_wb_addr != '0);
  assign w_pop     = !o_empty && i_drain_en;

  assign o_rd_wren = w_pop;
  assign o_rd_addr = o_empty ? '0 : r_addr[r_rd_ptr];
  assign o_rd_data = o_empty ? '0 : r_data[r_rd_ptr];

  // Pointers, occupancy and per-entry valid bits
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
        r_valid[r_rd_ptr] <= 1'b0;
      end
      if (w_push) begin
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
        r_valid[r_wr_ptr] <= 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Payload storage; contents are qualified by r_valid so no reset is needed
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= i_wb_addr;
      r_data[r_wr_ptr] <= i_wb_data;
    end
  end

  // Scan oldest to newest so the last match wins
  always_comb begin
    o_rs1_hit  = 1'b0;
    o_rs1_data = '0;
    o_rs2_hit  = 1'b0;
    o_rs2_data = '0;
    w_idx      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if (r_valid[w_idx] && (i_rs1_addr != '0) && (r_addr[w_idx] == i_rs1_addr)) begin
        o_rs1_hit  = 1'b1;
        o_rs1_data = r_data[w_idx];
      end
      if (r_valid[w_idx] && (i_rs2_addr != '0) && (r_addr[w_idx] == i_rs2_addr)) begin
        o_rs2_hit  = 1'b1;
        o_rs2_data = r_data[w_idx];
      end
    end
  end

endmodule
